// File: rtl/voxel_gpu_fb_ctrl_if.sv
// -----------------------------------------------------------------------------
// voxel_gpu_fb_ctrl_if
// Avalon-MM style bus bundle used for both the register slave port and the
// clear-engine master port of the voxel GPU framebuffer controller.
//
// Parameters:
//   ADDR_W       address width (8 for the register slave, 32 for the master)
// Signals:
//   address      word/byte address          (master -> slave)
//   writedata    32-bit write data          (master -> slave)
//   write        write strobe               (master -> slave)
//   read         read strobe                (master -> slave)
//   readdata     32-bit read data           (slave -> master)
//   readdatavalid read data valid           (slave -> master)
//   waitrequest  stall                      (slave -> master)
// -----------------------------------------------------------------------------
interface voxel_gpu_fb_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [31:0]       writedata;
    logic              write;
    logic              read;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, writedata, write, read,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, writedata, write, read,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/voxel_gpu_fb_ctrl.sv
// -----------------------------------------------------------------------------
// voxel_gpu_fb_ctrl
// Framebuffer controller for the voxel GPU. Holds front/back buffer pointers,
// swaps them on the end-of-frame strobe once software requests it, and runs a
// clear engine that fills the back buffer with a replicated fill colour over
// an Avalon-MM master. A level interrupt reports swap and clear completion.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high reset
//   s1          register slave (8-bit word address; readdata combinational,
//               waitrequest/readdatavalid tied 0)
//   m1          clear-engine master (32-bit byte address, write only;
//               read tied 0, readdata/readdatavalid unused)
//   frame_done  one-cycle end-of-frame strobe from the video output
//   irq         level interrupt: irq_en & (swap_irq | clear_irq)
//
// Register map (word address):
//   0x00 FRONT  R: front pointer, W: any value requests a swap
//   0x01 BACK   R/W back pointer
//   0x02 STATUS RO {clear_irq, swap_irq, clear_busy, swap_pending}
//   0x03 CTRL   bit0 irq_en; W bit2 clears swap_irq, W bit3 clears clear_irq
//   0x04 FILL   R/W, low PIXEL_BYTES*8 bits kept
//   0x05 CLEAR  W bit0 starts a clear; reads 0
//   0x06 PERF   RO cycles of the last clear (only with VOXEL_GPU_PERF_EN)
//
// Build option: define VOXEL_GPU_PERF_EN to include the clear cycle counter.
// -----------------------------------------------------------------------------
module voxel_gpu_fb_ctrl #(
    parameter logic [31:0] DEFAULT_BUFFER      = 32'h0800_0000,
    parameter logic [31:0] DEFAULT_BACK_BUFFER = 32'h0800_0000,
    parameter int          H_RES               = 320,
    parameter int          V_RES               = 240,
    parameter int          PIXEL_BYTES         = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    voxel_gpu_fb_ctrl_if.slave      s1,
    voxel_gpu_fb_ctrl_if.master     m1,
    input  logic                    frame_done,
    output logic                    irq
);

    localparam int          WORDS      = (H_RES * V_RES * PIXEL_BYTES) / 4;
    localparam logic [31:0] LAST_INDEX = 32'(WORDS - 1);
    localparam logic [31:0] FILL_MASK  = (PIXEL_BYTES == 4) ? 32'hFFFF_FFFF :
                                         (PIXEL_BYTES == 2) ? 32'h0000_FFFF :
                                                              32'h0000_00FF;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] front;
    logic [31:0] back;
    logic [31:0] fill;
    logic        irq_en;
    logic        swap_pending;
    logic        swap_irq;
    logic        clear_irq;
    logic [31:0] base;
    logic [31:0] fill_word;
    logic [31:0] index;

    logic        sel_front;
    logic        sel_back;
    logic        sel_ctrl;
    logic        sel_fill;
    logic        start;
    logic        clear_busy;
    logic        accept;
    logic        last_accept;
    logic        do_swap;

    // Spread one pixel of fill colour across a full 32-bit bus word.
    function automatic logic [31:0] replicate_fill(input logic [31:0] f);
        logic [31:0] r;
        case (PIXEL_BYTES)
            1:       r = {4{f[7:0]}};
            2:       r = {2{f[15:0]}};
            default: r = f;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign sel_front   = s1.write && (s1.address == 8'h00);
    assign sel_back    = s1.write && (s1.address == 8'h01);
    assign sel_ctrl    = s1.write && (s1.address == 8'h03);
    assign sel_fill    = s1.write && (s1.address == 8'h04);
    assign start       = s1.write && (s1.address == 8'h05) && s1.writedata[0];

    assign clear_busy  = (state == WRITE);
    assign accept      = clear_busy && !m1.waitrequest;
    assign last_accept = accept && (index == LAST_INDEX);
    // A clear in progress owns the back buffer, so frame_done cannot swap.
    assign do_swap     = frame_done && swap_pending && !clear_busy;

    assign irq             = irq_en && (swap_irq || clear_irq);
    assign s1.waitrequest  = 1'b0;
    assign s1.readdatavalid = 1'b0;

    // Master outputs derive from the state register so an asynchronous reset
    // drops m1.write in the same instant.
    assign m1.write     = clear_busy;
    assign m1.read      = 1'b0;
    assign m1.address   = clear_busy ? (base + (index << 2)) : 32'h0;
    assign m1.writedata = clear_busy ? fill_word : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)       state_next = WRITE;
            WRITE:   if (last_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            front        <= DEFAULT_BUFFER;
            back         <= DEFAULT_BACK_BUFFER;
            fill         <= 32'h0;
            irq_en       <= 1'b0;
            swap_pending <= 1'b0;
            swap_irq     <= 1'b0;
            clear_irq    <= 1'b0;
            base         <= 32'h0;
            fill_word    <= 32'h0;
            index        <= 32'h0;
        end else begin
            if (do_swap) begin
                front <= back;
            end
            // A software BACK write in the swap cycle takes precedence.
            if (sel_back) begin
                back <= s1.writedata;
            end else if (do_swap) begin
                back <= front;
            end

            if (do_swap) begin
                swap_pending <= 1'b0;
            end else if (sel_front) begin
                swap_pending <= 1'b1;
            end

            if (sel_fill) begin
                fill <= s1.writedata & FILL_MASK;
            end
            if (sel_ctrl) begin
                irq_en <= s1.writedata[0];
            end

            // Hardware event wins over a software clear in the same cycle.
            if (do_swap) begin
                swap_irq <= 1'b1;
            end else if (sel_ctrl && s1.writedata[2]) begin
                swap_irq <= 1'b0;
            end
            if (last_accept) begin
                clear_irq <= 1'b1;
            end else if (sel_ctrl && s1.writedata[3]) begin
                clear_irq <= 1'b0;
            end

            // The running clear works on its own snapshot of base and colour.
            if (!clear_busy && start) begin
                base      <= back;
                fill_word <= replicate_fill(fill);
                index     <= 32'h0;
            end else if (accept) begin
                index <= index + 32'd1;
            end
        end
    end

`ifdef VOXEL_GPU_PERF_EN
    logic [31:0] perf_run;
    logic [31:0] perf_last;

    // Every cycle spent in WRITE counts, stalls included.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_run  <= 32'h0;
            perf_last <= 32'h0;
        end else begin
            if (!clear_busy && start) begin
                perf_run <= 32'h0;
            end else if (clear_busy) begin
                perf_run <= sat_inc(perf_run);
            end
            if (last_accept) begin
                perf_last <= sat_inc(perf_run);
            end
        end
    end
`endif

    always_comb begin
        s1.readdata = 32'h0;
        case (s1.address)
            8'h00: s1.readdata = front;
            8'h01: s1.readdata = back;
            8'h02: s1.readdata = {28'h0, clear_irq, swap_irq, clear_busy, swap_pending};
            8'h03: s1.readdata = {31'h0, irq_en};
            8'h04: s1.readdata = fill;
`ifdef VOXEL_GPU_PERF_EN
            8'h06: s1.readdata = perf_last;
`endif
            default: s1.readdata = 32'h0;
        endcase
    end

endmodule
